button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
- Collects single-cycle press pulses from NUM_BTN button debouncers.
- Latches each pulse as a pending request.
- Serves pending requests round-robin to one downstream consumer as button-ID events over a valid/ready handshake.
- Enforces a hold-off gap between served events and flags lost presses (pulse arriving while the same button is already pending).

Parameters:
- NUM_BTN, 4: number of button pulse inputs; legal range 2..16.
- ID_W, 2: width of evt_id; must satisfy 2**ID_W >= NUM_BTN.
- HOLDOFF_CYCLES, 3: idle cycles after each accepted event before the next offer; legal range 0..255.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- pulse_in, input, NUM_BTN: one-cycle-high press pulses from the debouncers; bit i = button i.
- evt_valid, output, 1: event offered.
- evt_id, output, ID_W: button index of the offered event; valid only while evt_valid=1.
- evt_ready, input, 1: consumer accepts; the transfer occurs on a cycle where evt_valid & evt_ready.
- pending, output, NUM_BTN: registered pending-request vector.
- overflow, output, 1: sticky lost-press flag.
- ovf_clr, input, 1: clears overflow.

Behaviour:
- Reset (clk edge with rst=1):
  - pending=0, evt_valid=0, evt_id=0, overflow=0.
  - rr_ptr=0, holdoff counter=0, state=IDLE.
  - Reset takes priority over all other inputs, including mid-handshake: an offered event is dropped and not re-offered.
- pending[i] update:
  - Set when pulse_in[i]=1.
  - Cleared on the transfer cycle when evt_id=i.
  - Set wins over clear: a pulse on the granted bit during its transfer cycle leaves pending[i]=1 and is a new event, not an overflow.
- overflow:
  - Set when pulse_in[i]=1 while pending[i]=1 and bit i is not being cleared that cycle.
  - Cleared by ovf_clr; set wins over a simultaneous ovf_clr.
- State machine, 3 states, one-hot encoded:
  - IDLE:
    - If pending != 0: select the first set bit searching upward from rr_ptr, wrapping NUM_BTN-1 -> 0.
    - Register the selected index into evt_id, set evt_valid=1, go to OFFER.
    - Otherwise stay in IDLE.
    - Pulses arriving in the same cycle are not considered; they become visible in pending the next cycle.
  - OFFER:
    - evt_valid=1; evt_id held stable until transfer.
    - Higher-priority pulses arriving during OFFER never preempt the current offer.
    - On evt_ready: evt_valid=0, clear pending[evt_id], rr_ptr = evt_id+1 (wrapping to 0 after NUM_BTN-1).
    - After transfer: if HOLDOFF_CYCLES=0 go to IDLE; else load counter=HOLDOFF_CYCLES and go to HOLDOFF.
  - HOLDOFF:
    - evt_valid=0; counter decrements each cycle.
    - When counter=1, go to IDLE on that edge.
    - Pulses are still latched into pending.
  - Illegal state: return to IDLE with evt_valid=0.
- Latency:
  - Pulse sampled at edge k -> pending visible after k -> evt_valid=1 after edge k+1, i.e. 2 cycles from pulse to offer.
  - Minimum spacing between transfers: HOLDOFF_CYCLES+2 cycles (HOLDOFF, then IDLE, then OFFER).
- evt_ready is ignored while evt_valid=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package button_pkg:
  - State encodings ARB_IDLE=3'b001, ARB_OFFER=3'b010, ARB_HOLDOFF=3'b100.
  - Constant MAX_BTN=16.
- Sub-module rr_pick: purely combinational. Inputs req[NUM_BTN] and ptr[ID_W]; outputs any and idx[ID_W] (first set bit at or above ptr, with wrap).
- Top-level owns pending, overflow, the FSM, the counter and rr_ptr.

Test Plan:
- Single press, evt_ready tied 1:
  - pulse_in=4'b0100 at cycle 0 -> pending=4'b0100 at cycle 1, evt_valid=1 with evt_id=2 at cycle 2.
  - Transfer at cycle 2; pending=0 at cycle 3; evt_valid stays 0 through cycle 6 (HOLDOFF=3 plus IDLE).
- Simultaneous presses, round-robin order:
  - pulse_in=4'b1011 in one cycle, evt_ready=1 -> evt_id sequence 0, 1, 3 with transfers 5 cycles apart; rr_ptr ends at 0.
  - Then pulse_in=4'b0011 -> served 0 then 1.
- Backpressure:
  - evt_ready=0 for 10 cycles while a pulse arrives on button 0 during OFFER of id 2 -> evt_id stays 2 and evt_valid stays 1.
  - evt_ready=1 -> id 2 transfers, then id 0 is offered next (wrap from rr_ptr=3).
- Overflow:
  - Button 1 pulses twice while held in OFFER of id 3 -> overflow=1.
  - A pulse on id 3 in its own transfer cycle -> no overflow, id 3 re-offered later.
  - ovf_clr and a new overflow in the same cycle -> overflow stays 1.
- Reset mid-operation:
  - rst=1 for one cycle during OFFER with pending=4'b1110 -> next cycle evt_valid=0, pending=0, overflow=0, state IDLE.
  - A new pulse on button 3 -> offered with evt_id=3 two cycles later (rr_ptr restarted at 0).
- Parameter corner:
  - NUM_BTN=3, ID_W=2, HOLDOFF_CYCLES=0, pulse_in=3'b111, evt_ready=1 -> ids 0, 1, 2, with transfers every 2 cycles; no index 3 is ever produced.

Source files
------------

// File: rtl/button_event_arbiter_pkg.sv
// Shared types and constants for the button event arbiter.
package button_pkg;

   localparam int unsigned MAX_BTN = 16;
   localparam int unsigned CNT_W   = 8;

   typedef enum logic [2:0] {
      ARB_IDLE    = 3'b001,
      ARB_OFFER   = 3'b010,
      ARB_HOLDOFF = 3'b100
   } arb_state_t;

endpackage

// File: rtl/button_event_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick
   import button_pkg::*;
#(
   parameter int unsigned NUM_BTN = 4,
   parameter int unsigned ID_W    = 2
)
(
   input  logic [NUM_BTN-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic               any,
   output logic [ID_W-1:0]    idx
);

   // Pick the requester with the smallest wrapped distance from ptr.
   always_comb begin
      int unsigned w_best;
      int unsigned w_dist;
      int unsigned w_ptr;
      any    = 1'b0;
      idx    = '0;
      w_best = NUM_BTN;
      w_dist = 0;
      w_ptr  = 32'(ptr);
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         if (req[i]) begin
            w_dist = (i >= w_ptr) ? (i - w_ptr) : (i + NUM_BTN - w_ptr);
            if (w_dist < w_best) begin
               w_best = w_dist;
               idx    = ID_W'(i);
               any    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/button_event_arbiter.sv
// Latches button press pulses and serves them round-robin as ID events
// over valid/ready, with a hold-off gap and a sticky lost-press flag.
module button_event_arbiter
   import button_pkg::*;
#(
   parameter int unsigned NUM_BTN        = 4,
   parameter int unsigned ID_W           = 2,
   parameter int unsigned HOLDOFF_CYCLES = 3
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] pulse_in,
   output logic               evt_valid,
   output logic [ID_W-1:0]    evt_id,
   input  logic               evt_ready,
   output logic [NUM_BTN-1:0] pending,
   output logic               overflow,
   input  logic               ovf_clr
);

   arb_state_t         r_state;
   arb_state_t         w_state_nxt;
   logic [NUM_BTN-1:0] r_pending;
   logic [NUM_BTN-1:0] w_clr_mask;
   logic               r_overflow;
   logic               w_ovf_set;
   logic               r_evt_valid;
   logic               w_evt_valid_nxt;
   logic [ID_W-1:0]    r_evt_id;
   logic [ID_W-1:0]    w_evt_id_nxt;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [ID_W-1:0]    w_rr_ptr_nxt;
   logic [ID_W-1:0]    w_ptr_inc;
   logic [ID_W-1:0]    w_pick_idx;
   logic               w_pick_any;
   logic               w_xfer;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;

   rr_pick #(
      .NUM_BTN (NUM_BTN),
      .ID_W    (ID_W)
   ) u_pick (
      .req (r_pending),
      .ptr (r_rr_ptr),
      .any (w_pick_any),
      .idx (w_pick_idx)
   );

   assign w_xfer    = r_evt_valid & evt_ready;
   assign w_ptr_inc = (r_evt_id == ID_W'(NUM_BTN - 1)) ? '0 : r_evt_id + ID_W'(1);

   // Bit being retired by this cycle's transfer, if any.
   always_comb begin
      w_clr_mask = '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         w_clr_mask[i] = w_xfer && (r_evt_id == ID_W'(i));
      end
   end

   // A press is lost only if its bit stays pending through this edge.
   assign w_ovf_set = |(pulse_in & r_pending & ~w_clr_mask);

   // Pending requests and sticky overflow; new pulses win over clears.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending  <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_pending  <= (r_pending & ~w_clr_mask) | pulse_in;
         r_overflow <= w_ovf_set | (r_overflow & ~ovf_clr);
      end
   end

   // FSM state and registered offer/pointer/counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_evt_valid <= 1'b0;
         r_evt_id    <= '0;
         r_rr_ptr    <= '0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_evt_valid <= w_evt_valid_nxt;
         r_evt_id    <= w_evt_id_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_cnt       <= w_cnt_nxt;
      end
   end

   // Next-state decision.
   always_comb begin
      w_state_nxt = ARB_IDLE;
      case (r_state)
         ARB_IDLE:    w_state_nxt = w_pick_any ? ARB_OFFER : ARB_IDLE;
         ARB_OFFER: begin
            if (w_xfer) begin
               w_state_nxt = (HOLDOFF_CYCLES == 0) ? ARB_IDLE : ARB_HOLDOFF;
            end else begin
               w_state_nxt = ARB_OFFER;
            end
         end
         ARB_HOLDOFF: w_state_nxt = (r_cnt <= CNT_W'(1)) ? ARB_IDLE : ARB_HOLDOFF;
         default:     w_state_nxt = ARB_IDLE;
      endcase
   end

   // Next values of the registered outputs, pointer and hold-off counter.
   always_comb begin
      w_evt_valid_nxt = 1'b0;
      w_evt_id_nxt    = r_evt_id;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_cnt_nxt       = r_cnt;
      case (r_state)
         ARB_IDLE: begin
            if (w_pick_any) begin
               w_evt_valid_nxt = 1'b1;
               w_evt_id_nxt    = w_pick_idx;
            end
         end
         ARB_OFFER: begin
            w_evt_valid_nxt = ~w_xfer;
            if (w_xfer) begin
               w_rr_ptr_nxt = w_ptr_inc;
               w_cnt_nxt    = CNT_W'(HOLDOFF_CYCLES);
            end
         end
         ARB_HOLDOFF: w_cnt_nxt = r_cnt - CNT_W'(1);
         default: ;
      endcase
   end

   assign evt_valid = r_evt_valid;
   assign evt_id    = r_evt_id;
   assign pending   = r_pending;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Scoreboard bench: two arbiter instances (4 buttons/holdoff 3 and
// 3 buttons/holdoff 0) checked against a behavioural reference model.
module tb_button_event_arbiter;

   localparam int NB0 = 4;
   localparam int HD0 = 3;
   localparam int NB1 = 3;
   localparam int HD1 = 0;

   typedef struct {
      int id;
      int cyc;
   } ev_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0] pulse0 = '0;
   logic       rdy0 = 1'b0, clr0 = 1'b0, rst0 = 1'b0;
   logic       v0, ovf0;
   logic [1:0] id0;
   logic [3:0] pend0;

   logic [2:0] pulse1 = '0;
   logic       rdy1 = 1'b0, clr1 = 1'b0, rst1 = 1'b0;
   logic       v1, ovf1;
   logic [1:0] id1;
   logic [2:0] pend1;

   button_event_arbiter #(.NUM_BTN(NB0), .ID_W(2), .HOLDOFF_CYCLES(HD0)) dut0 (
      .clk(clk), .rst(rst0), .pulse_in(pulse0), .evt_valid(v0), .evt_id(id0),
      .evt_ready(rdy0), .pending(pend0), .overflow(ovf0), .ovf_clr(clr0)
   );

   button_event_arbiter #(.NUM_BTN(NB1), .ID_W(2), .HOLDOFF_CYCLES(HD1)) dut1 (
      .clk(clk), .rst(rst1), .pulse_in(pulse1), .evt_valid(v1), .evt_id(id1),
      .evt_ready(rdy1), .pending(pend1), .overflow(ovf1), .ovf_clr(clr1)
   );

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   bit done1 = 1'b0;

   // Reference model state per instance.
   bit [15:0] m_pend[2];
   bit        m_ovf[2];
   int        m_ptr[2];
   bit        m_offer[2];
   int        m_id[2];
   int        m_next_ok[2];
   bit        m_init[2];
   bit        prev_v[2];
   ev_t       q0[$];
   ev_t       q1[$];

   task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s u%0d cycle %0d: got %0h expected %0h", name, u, cyc, act, exp);
      end
   endtask

   // Model: pending set, round-robin pick, and the rule that after a
   // transfer at edge t the next offer may not launch before t+HOLDOFF+1.
   task automatic model_step(input int u, input bit [15:0] p, input bit rdy, input bit clr, input bit rs);
      bit [15:0] np;
      bit        xfer;
      bit        ovs;
      int        n, hd, pick;
      ev_t       e;
      n  = (u == 0) ? NB0 : NB1;
      hd = (u == 0) ? HD0 : HD1;
      if (rs) begin
         m_pend[u] = '0; m_ovf[u] = 1'b0; m_ptr[u] = 0; m_offer[u] = 1'b0;
         m_id[u] = 0; m_next_ok[u] = cyc + 1; m_init[u] = 1'b1;
         return;
      end
      if (!m_init[u]) return;
      xfer = m_offer[u] && rdy;
      np = m_pend[u];
      if (xfer) np &= ~(16'd1 << m_id[u]);
      ovs = |(p & np);
      np |= p;
      if (!m_offer[u] && cyc >= m_next_ok[u] && m_pend[u] != '0) begin
         pick = -1;
         for (int k = 0; k < n; k++) begin
            int j;
            j = (m_ptr[u] + k) % n;
            if (pick < 0 && ((m_pend[u] >> j) & 16'd1) != 16'd0) pick = j;
         end
         m_offer[u] = 1'b1;
         m_id[u] = pick;
         e.id = pick;
         e.cyc = cyc;
         if (u == 0) q0.push_back(e); else q1.push_back(e);
      end
      if (xfer) begin
         m_offer[u] = 1'b0;
         m_ptr[u] = (m_id[u] + 1) % n;
         m_next_ok[u] = cyc + hd + 1;
      end
      m_ovf[u] = ovs | (m_ovf[u] & !clr);
      m_pend[u] = np;
   endtask

   always @(posedge clk) begin
      cyc++;
      model_step(0, {12'b0, pulse0}, rdy0, clr0, rst0);
      model_step(1, {13'b0, pulse1}, rdy1, clr1, rst1);
   end

   // Monitor: per-cycle state checks plus scoreboard pop on each new offer.
   task automatic mon(input int u, input logic v, input logic [1:0] id, input logic [15:0] pd, input logic ov);
      ev_t e;
      bit  empty;
      if (!m_init[u]) return;
      chk("evt_valid", u, 32'(v), 32'(m_offer[u]));
      chk("pending", u, 32'(pd), 32'(m_pend[u]));
      chk("overflow", u, 32'(ov), 32'(m_ovf[u]));
      if (v === 1'b1 && !prev_v[u]) begin
         empty = (u == 0) ? (q0.size() == 0) : (q1.size() == 0);
         if (empty) begin
            nchk++;
            nerr++;
            $display("FAIL offer_unexpected u%0d cycle %0d: got id %0d expected no offer", u, cyc, id);
         end else begin
            if (u == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk("offer_id", u, 32'(id), e.id);
            chk("offer_cycle", u, cyc, e.cyc);
         end
      end else if (v === 1'b1) begin
         chk("evt_id_hold", u, 32'(id), m_id[u]);
      end
      prev_v[u] = (v === 1'b1);
   endtask

   always @(negedge clk) begin
      mon(0, v0, id0, {12'b0, pend0}, ovf0);
      mon(1, v1, id1, {13'b0, pend1}, ovf1);
   end

   task automatic drive0(input logic [3:0] p, input logic rdy, input logic clr, input logic rs);
      pulse0 = p; rdy0 = rdy; clr0 = clr; rst0 = rs;
      @(negedge clk);
   endtask

   task automatic idle0(input int n, input logic rdy);
      for (int i = 0; i < n; i++) drive0(4'b0000, rdy, 1'b0, 1'b0);
   endtask

   task automatic drive1(input logic [2:0] p, input logic rdy, input logic clr, input logic rs);
      pulse1 = p; rdy1 = rdy; clr1 = clr; rst1 = rs;
      @(negedge clk);
   endtask

   // Instance 1: all three buttons at once with holdoff 0, then random.
   initial begin
      drive1(3'b000, 1'b0, 1'b0, 1'b1);
      drive1(3'b000, 1'b0, 1'b0, 1'b1);
      drive1(3'b111, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) drive1(3'b000, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 500; i++) begin
         drive1(($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
                $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                $urandom_range(0, 149) == 0);
      end
      for (int i = 0; i < 20; i++) drive1(3'b000, 1'b1, 1'b0, 1'b0);
      done1 = 1'b1;
   end

   initial begin
      drive0(4'b0000, 1'b0, 1'b0, 1'b1);
      drive0(4'b0000, 1'b0, 1'b0, 1'b1);
      // single press
      drive0(4'b0100, 1'b1, 1'b0, 1'b0);
      idle0(8, 1'b1);
      // simultaneous presses, then a second batch
      drive0(4'b1011, 1'b1, 1'b0, 1'b0);
      idle0(18, 1'b1);
      drive0(4'b0011, 1'b1, 1'b0, 1'b0);
      idle0(12, 1'b1);
      // backpressure with a lower-index press arriving during the offer
      drive0(4'b0100, 1'b0, 1'b0, 1'b0);
      idle0(3, 1'b0);
      drive0(4'b0001, 1'b0, 1'b0, 1'b0);
      idle0(6, 1'b0);
      idle0(15, 1'b1);
      // overflow, then a press on the granted button in its transfer cycle
      drive0(4'b1000, 1'b0, 1'b0, 1'b0);
      idle0(2, 1'b0);
      drive0(4'b0010, 1'b0, 1'b0, 1'b0);
      drive0(4'b0000, 1'b0, 1'b0, 1'b0);
      drive0(4'b0010, 1'b0, 1'b0, 1'b0);
      drive0(4'b1000, 1'b1, 1'b0, 1'b0);
      idle0(20, 1'b1);
      // clear racing a new overflow
      drive0(4'b0000, 1'b1, 1'b1, 1'b0);
      drive0(4'b0001, 1'b0, 1'b0, 1'b0);
      idle0(3, 1'b0);
      drive0(4'b0001, 1'b0, 1'b1, 1'b0);
      idle0(2, 1'b0);
      idle0(8, 1'b1);
      // reset during an offer
      drive0(4'b1110, 1'b0, 1'b0, 1'b0);
      idle0(3, 1'b0);
      drive0(4'b0000, 1'b0, 1'b0, 1'b1);
      drive0(4'b1000, 1'b1, 1'b0, 1'b0);
      idle0(8, 1'b1);
      // random traffic
      for (int i = 0; i < 700; i++) begin
         drive0(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                $urandom_range(0, 149) == 0);
      end
      idle0(40, 1'b1);
      for (int k = 0; k < 2000 && !done1; k++) @(negedge clk);
      @(negedge clk);
      chk("queue0_empty", 0, q0.size(), 0);
      chk("queue1_empty", 1, q1.size(), 0);
      chk("drained_pending", 0, 32'(pend0), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
